// File: rtl/tpu_pkg.sv
// Shared constants, state encoding and helpers for the norm output collector.
// Contents:
//   DESIGN_SIZE / DWIDTH / AWIDTH / MASK_WIDTH - datapath geometry
//   CNT_W / COL_W / ENTRY_W                    - derived widths
//   coll_state_e                               - collector state encoding
//   num_cols_legal()                           - range check for a programmed column count
package tpu_pkg;

  localparam int DESIGN_SIZE = 4;
  localparam int DWIDTH      = 8;
  localparam int AWIDTH      = 10;
  localparam int MASK_WIDTH  = 4;

  localparam int CNT_W   = $clog2(DESIGN_SIZE) + 1;
  localparam int COL_W   = DESIGN_SIZE * DWIDTH;
  localparam int ENTRY_W = COL_W + MASK_WIDTH;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } coll_state_e;

  // A run may only be armed with 1..DESIGN_SIZE columns.
  function automatic logic num_cols_legal(input logic [CNT_W-1:0] n);
    return (n != {CNT_W{1'b0}}) && (n <= CNT_W'(DESIGN_SIZE));
  endfunction

endpackage

// File: rtl/norm_out_collector_if.sv
// Column-stream and BRAM write-port bundle of the norm output collector.
// Signals:
//   in_data_available, inp_data, validity_mask - column stream from the norm block
//   bram_ready                                 - BRAM accepts a write this cycle
//   bram_we, bram_be, bram_addr, bram_wdata    - BRAM write port
// Modports:
//   slave  - the collector (consumes columns, drives the BRAM port)
//   master - the environment (produces columns, acts as the BRAM)
interface norm_out_collector_if;
  import tpu_pkg::*;

  logic                  in_data_available;
  logic [COL_W-1:0]      inp_data;
  logic [MASK_WIDTH-1:0] validity_mask;
  logic                  bram_ready;
  logic                  bram_we;
  logic [MASK_WIDTH-1:0] bram_be;
  logic [AWIDTH-1:0]     bram_addr;
  logic [COL_W-1:0]      bram_wdata;

  modport slave (
    input  in_data_available, inp_data, validity_mask, bram_ready,
    output bram_we, bram_be, bram_addr, bram_wdata
  );

  modport master (
    output in_data_available, inp_data, validity_mask, bram_ready,
    input  bram_we, bram_be, bram_addr, bram_wdata
  );

endinterface

// File: rtl/collector_skid_fifo.sv
// Two-entry skid FIFO with a registered head (no write-through bypass).
// Ports:
//   clk, resetn - clock, synchronous active-low reset
//   push_i      - enqueue wdata_i (accepted when not full, or when popping)
//   pop_i       - dequeue the head (ignored when empty)
//   wdata_i     - entry to enqueue
//   full_o      - two entries held
//   empty_o     - no entry held
//   head_o      - oldest entry, zero when empty
module collector_skid_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  logic [1:0]       count_q, count_d;
  logic [1:0]       level_s;
  logic [WIDTH-1:0] mem0_q, mem0_d;
  logic [WIDTH-1:0] mem1_q, mem1_d;
  logic             pop_s, push_s;

  assign pop_s  = pop_i && (count_q != 2'd0);
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_s = push_i && ((count_q != 2'd2) || pop_s);

  // Next-state: pop shifts slot 1 into the head, then push lands in the first free slot.
  always_comb begin
    mem0_d  = mem0_q;
    mem1_d  = mem1_q;
    level_s = count_q;
    count_d = count_q;
    if (pop_s) begin
      mem0_d  = mem1_q;
      mem1_d  = {WIDTH{1'b0}};
      level_s = count_q - 2'd1;
    end else begin
      level_s = count_q;
    end
    if (push_s) begin
      if (level_s == 2'd0) begin
        mem0_d = wdata_i;
      end else begin
        mem1_d = wdata_i;
      end
      count_d = level_s + 2'd1;
    end else begin
      count_d = level_s;
    end
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      count_q <= 2'd0;
      mem0_q  <= {WIDTH{1'b0}};
      mem1_q  <= {WIDTH{1'b0}};
    end else begin
      count_q <= count_d;
      mem0_q  <= mem0_d;
      mem1_q  <= mem1_d;
    end
  end

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign head_o  = mem0_q;

endmodule

// File: rtl/norm_out_collector.sv
// Collects the normalization block's column stream and writes each column to
// the result BRAM at base_addr + k*addr_stride, absorbing BRAM back-pressure
// in a 2-entry skid FIFO (the norm side cannot be stalled).
// Ports:
//   clk, resetn   - clock, synchronous active-low reset
//   start_collect - one-cycle pulse arming a run (IDLE or DONE only)
//   base_addr     - first write address, sampled on start
//   addr_stride   - address increment per column, sampled on start
//   num_cols      - columns expected (1..DESIGN_SIZE), sampled on start
//   bus           - column stream in, BRAM write port out
//   busy          - run in progress
//   done_collect  - held from completion until the next accepted start
//   overflow_err  - sticky, a column was dropped on a full FIFO
module norm_out_collector
  import tpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start_collect,
  input  logic [AWIDTH-1:0]    base_addr,
  input  logic [AWIDTH-1:0]    addr_stride,
  input  logic [CNT_W-1:0]     num_cols,
  norm_out_collector_if.slave  bus,
  output logic                 busy,
  output logic                 done_collect,
  output logic                 overflow_err
);

  coll_state_e          state_q;
  logic [AWIDTH-1:0]    addr_q;
  logic [AWIDTH-1:0]    stride_q;
  logic [CNT_W-1:0]     num_cols_q;
  logic [CNT_W-1:0]     rx_count_q;
  logic [CNT_W-1:0]     wr_count_q;
  logic [CNT_W-1:0]     drop_count_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 ovf_q;

  logic                 fifo_full_s;
  logic                 fifo_empty_s;
  logic [ENTRY_W-1:0]   head_s;
  logic                 cap_s;
  logic                 pop_s;
  logic                 push_s;
  logic                 drop_s;
  logic                 complete_s;

  // Columns beyond the programmed count are simply not captured.
  assign cap_s  = (state_q == COLLECT) && bus.in_data_available && (rx_count_q < num_cols_q);
  assign pop_s  = (state_q == COLLECT) && !fifo_empty_s && bus.bram_ready;
  assign push_s = cap_s && (!fifo_full_s || pop_s);
  assign drop_s = cap_s && fifo_full_s && !pop_s;

  // Dropped columns count toward completion so a run with overflow still finishes.
  assign complete_s = ({1'b0, wr_count_q} + {1'b0, drop_count_q} == {1'b0, num_cols_q})
                      && fifo_empty_s;

  collector_skid_fifo #(
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .wdata_i ({bus.inp_data, bus.validity_mask}),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .head_o  (head_s)
  );

  // Collector FSM with run parameters, counters and registered status flags.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      addr_q       <= {AWIDTH{1'b0}};
      stride_q     <= {AWIDTH{1'b0}};
      num_cols_q   <= {CNT_W{1'b0}};
      rx_count_q   <= {CNT_W{1'b0}};
      wr_count_q   <= {CNT_W{1'b0}};
      drop_count_q <= {CNT_W{1'b0}};
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_collect && num_cols_legal(num_cols)) begin
            state_q      <= COLLECT;
            addr_q       <= base_addr;
            stride_q     <= addr_stride;
            num_cols_q   <= num_cols;
            rx_count_q   <= {CNT_W{1'b0}};
            wr_count_q   <= {CNT_W{1'b0}};
            drop_count_q <= {CNT_W{1'b0}};
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            ovf_q        <= 1'b0;
          end else begin
            state_q <= state_q;
          end
        end
        COLLECT: begin
          if (push_s || drop_s) begin
            rx_count_q <= rx_count_q + CNT_W'(1);
          end else begin
            rx_count_q <= rx_count_q;
          end
          if (drop_s) begin
            drop_count_q <= drop_count_q + CNT_W'(1);
            ovf_q        <= 1'b1;
          end else begin
            drop_count_q <= drop_count_q;
          end
          // Address wraps modulo 2^AWIDTH by construction.
          if (pop_s) begin
            addr_q     <= addr_q + stride_q;
            wr_count_q <= wr_count_q + CNT_W'(1);
          end else begin
            addr_q     <= addr_q;
          end
          if (complete_s) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= COLLECT;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.bram_we    = !fifo_empty_s;
  assign bus.bram_be    = head_s[MASK_WIDTH-1:0];
  assign bus.bram_wdata = head_s[ENTRY_W-1:MASK_WIDTH];
  assign bus.bram_addr  = addr_q;

  assign busy         = busy_q;
  assign done_collect = done_q;
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_norm_out_collector.sv
module tb_norm_out_collector;
  import tpu_pkg::*;

  logic                  clk = 1'b0;
  logic                  resetn;
  logic                  start_collect;
  logic [AWIDTH-1:0]     base_addr;
  logic [AWIDTH-1:0]     addr_stride;
  logic [CNT_W-1:0]      num_cols;
  logic                  busy;
  logic                  done_collect;
  logic                  overflow_err;

  norm_out_collector_if bus ();

  norm_out_collector dut (
    .clk           (clk),
    .resetn        (resetn),
    .start_collect (start_collect),
    .base_addr     (base_addr),
    .addr_stride   (addr_stride),
    .num_cols      (num_cols),
    .bus           (bus),
    .busy          (busy),
    .done_collect  (done_collect),
    .overflow_err  (overflow_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // stimulus table for one run (one entry per cycle after the start pulse)
  logic                  av_t[$];
  logic                  rdy_t[$];
  logic [COL_W-1:0]      dat_t[$];
  logic [MASK_WIDTH-1:0] msk_t[$];

  // observed BRAM writes
  logic [AWIDTH-1:0]     act_addr[$];
  logic [COL_W-1:0]      act_data[$];
  logic [MASK_WIDTH-1:0] act_be[$];
  int cyc, last_wr_cyc, done_cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_tables();
    av_t.delete(); rdy_t.delete(); dat_t.delete(); msk_t.delete();
  endtask

  task automatic add_col(input logic av, input logic [COL_W-1:0] d,
                         input logic [MASK_WIDTH-1:0] m, input logic r);
    av_t.push_back(av); dat_t.push_back(d); msk_t.push_back(m); rdy_t.push_back(r);
  endtask

  // one clock cycle: drive at the falling edge, sample 2ns later (3ns before the rising edge)
  task automatic tick(input logic av, input logic [COL_W-1:0] d,
                      input logic [MASK_WIDTH-1:0] m, input logic r);
    @(negedge clk);
    start_collect          = 1'b0;
    bus.in_data_available  = av;
    bus.inp_data           = d;
    bus.validity_mask      = m;
    bus.bram_ready         = r;
    #2;
    if (bus.bram_we === 1'b1 && bus.bram_ready === 1'b1) begin
      act_addr.push_back(bus.bram_addr);
      act_data.push_back(bus.bram_wdata);
      act_be.push_back(bus.bram_be);
      last_wr_cyc = cyc;
    end
    if (done_collect === 1'b1 && done_cyc < 0) done_cyc = cyc;
    cyc++;
  endtask

  task automatic start_run(input logic [AWIDTH-1:0] b, input logic [AWIDTH-1:0] s,
                           input logic [CNT_W-1:0] n);
    @(negedge clk);
    start_collect         = 1'b1;
    base_addr             = b;
    addr_stride           = s;
    num_cols              = n;
    bus.in_data_available = 1'b0;
    bus.bram_ready        = 1'b1;
    act_addr.delete(); act_data.delete(); act_be.delete();
    cyc = 0; last_wr_cyc = -1; done_cyc = -1;
  endtask

  typedef struct { logic [COL_W-1:0] d; logic [MASK_WIDTH-1:0] m; } col_t;

  // Run the table, drain, then compare against a queue-based reference of the column stream.
  task automatic run_and_check(input string name, input logic [AWIDTH-1:0] b,
                               input logic [AWIDTH-1:0] s, input int n);
    col_t q[$];
    col_t expw[$];
    col_t c;
    int   rx;
    logic ovf;
    int   ncyc;
    int   nmin;
    logic av, r;
    start_run(b, s, n[CNT_W-1:0]);
    for (int i = 0; i < av_t.size(); i++) tick(av_t[i], dat_t[i], msk_t[i], rdy_t[i]);
    for (int i = 0; i < 20 && done_cyc < 0; i++) tick(1'b0, '0, '0, 1'b1);
    repeat (2) tick(1'b0, '0, '0, 1'b1);
    ncyc = cyc;
    // reference: a write takes the oldest held column when ready; an arrival is kept
    // only if fewer than two columns remain held, but counts toward the run either way
    rx = 0; ovf = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      av = (i < av_t.size()) ? av_t[i] : 1'b0;
      r  = (i < av_t.size()) ? rdy_t[i] : 1'b1;
      if (q.size() > 0 && r) expw.push_back(q.pop_front());
      if (av && rx < n) begin
        rx++;
        c.d = dat_t[i]; c.m = msk_t[i];
        if (q.size() < 2) q.push_back(c);
        else ovf = 1'b1;
      end
    end
    chk({name, " nwrites"}, act_addr.size(), expw.size());
    nmin = (act_addr.size() < expw.size()) ? act_addr.size() : expw.size();
    for (int k = 0; k < nmin; k++) begin
      chk($sformatf("%s addr%0d", name, k), act_addr[k], (int'(b) + k * int'(s)) % 1024);
      chk($sformatf("%s data%0d", name, k), act_data[k], expw[k].d);
      chk($sformatf("%s be%0d", name, k), act_be[k], expw[k].m);
    end
    chk({name, " overflow"}, overflow_err, ovf);
    chk({name, " done"}, done_collect, 1'b1);
    chk({name, " busy"}, busy, 1'b0);
    chk({name, " done_latency"}, done_cyc - last_wr_cyc, 2);
  endtask

  initial begin
    logic [COL_W-1:0] d;
    int n;
    resetn = 1'b0; start_collect = 1'b0;
    base_addr = '0; addr_stride = '0; num_cols = '0;
    bus.in_data_available = 1'b0; bus.inp_data = '0; bus.validity_mask = '0; bus.bram_ready = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    chk("rst we", bus.bram_we, 1'b0);
    chk("rst be", bus.bram_be, 4'h0);
    chk("rst addr", bus.bram_addr, 10'h000);
    chk("rst wdata", bus.bram_wdata, 32'h0);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done_collect, 1'b0);
    chk("rst ovf", overflow_err, 1'b0);
    @(negedge clk); resetn = 1'b1;

    // 1: basic run
    clear_tables();
    for (int i = 0; i < 4; i++) begin
      d = {8'(4*i+4), 8'(4*i+3), 8'(4*i+2), 8'(4*i+1)};
      add_col(1'b1, d, 4'hF, 1'b1);
    end
    run_and_check("t1", 10'h010, 10'h001, 4);
    chk("t1 last addr", act_addr[act_addr.size()-1], 10'h013);
    chk("t1 first data", act_data[0], 32'h04030201);

    // 2: address wrap
    run_and_check("t2", 10'h001, 10'h3FF, 4);
    chk("t2 addr2 wrap", act_addr[2], 10'h3FF);

    // 3: back-pressure with overflow
    clear_tables();
    for (int i = 0; i < 4; i++) add_col(1'b1, 32'hA0A0_0000 + 32'(i), 4'hF, 1'b0);
    run_and_check("t3", 10'h100, 10'h004, 4);
    chk("t3 two writes", act_addr.size(), 2);
    chk("t3 ovf set", overflow_err, 1'b1);
    chk("t3 second col", act_data[1], 32'hA0A0_0001);

    // 4: toggling ready, no drops
    clear_tables();
    for (int i = 0; i < 4; i++) add_col(1'b1, 32'hB0B0_0000 + 32'(i), 4'hF, (i % 2) == 1);
    run_and_check("t4", 10'h200, 10'h002, 4);
    chk("t4 four writes", act_addr.size(), 4);
    chk("t4 no ovf", overflow_err, 1'b0);

    // 5: partial mask
    clear_tables();
    for (int i = 0; i < 4; i++) add_col(1'b1, $urandom, 4'b0101, 1'b1);
    run_and_check("t5", 10'h040, 10'h001, 4);
    chk("t5 be", act_be[3], 4'b0101);

    // randomized runs
    for (int r = 0; r < 8; r++) begin
      clear_tables();
      n = int'($urandom_range(1, DESIGN_SIZE));
      for (int i = 0; i < 10; i++)
        add_col(($urandom % 4) != 0, $urandom, 4'($urandom), ($urandom % 2) == 0);
      run_and_check($sformatf("rnd%0d", r), 10'($urandom), 10'($urandom), n);
    end

    // 6: reset mid-run, then illegal starts
    clear_tables();
    start_run(10'h020, 10'h001, 3'd4);
    tick(1'b1, 32'h11111111, 4'hF, 1'b1);
    tick(1'b1, 32'h22222222, 4'hF, 1'b1);
    tick(1'b1, 32'h33333333, 4'hF, 1'b1);
    chk("t6 writes before rst", act_addr.size(), 2);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    #2;
    chk("t6 we", bus.bram_we, 1'b0);
    chk("t6 be", bus.bram_be, 4'h0);
    chk("t6 addr", bus.bram_addr, 10'h000);
    chk("t6 wdata", bus.bram_wdata, 32'h0);
    chk("t6 busy", busy, 1'b0);
    resetn = 1'b1;
    repeat (3) tick(1'b1, 32'h44444444, 4'hF, 1'b1);
    chk("t6 no writes after rst", act_addr.size(), 2);
    chk("t6 idle ovf", overflow_err, 1'b0);
    start_run(10'h000, 10'h001, 3'd0);
    repeat (3) tick(1'b1, 32'h55555555, 4'hF, 1'b1);
    chk("t6 num0 busy", busy, 1'b0);
    chk("t6 num0 writes", act_addr.size(), 0);
    start_run(10'h000, 10'h001, 3'd5);
    repeat (3) tick(1'b1, 32'h66666666, 4'hF, 1'b1);
    chk("t6 num5 busy", busy, 1'b0);
    chk("t6 num5 done", done_collect, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
